// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared bus widths, owner encodings and grant type for the memory arbiter
package mem_bus_arbiter_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 8;
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;
    typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_DMA} gnt_e;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: CPU, DMA and memory port signals of the shared 6502 bus
interface mem_bus_arbiter_if #(
    parameter int AW = mem_bus_arbiter_pkg::AW_DEF,
    parameter int DW = mem_bus_arbiter_pkg::DW_DEF
);
    logic          cpu_req, cpu_we, cpu_lock, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we, bus_owner;
    logic [DW-1:0] mem_wdata, mem_rdata;
    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_wdata, cpu_lock,
        input  dma_req, dma_addr, dma_we, dma_wdata, mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_we, mem_wdata, bus_owner
    );
    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_wdata, cpu_lock,
        output dma_req, dma_addr, dma_we, dma_wdata, mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_we, mem_wdata, bus_owner
    );
endinterface

// File: rtl/arb_burst_ctr.sv
// arb_burst_ctr: saturating count of consecutive DMA grants, sat flags the burst limit
module arb_burst_ctr #(
    parameter int MAX = 4,
    localparam int W = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    logic [W-1:0] cnt_q, cnt_d;
    assign sat = cnt_q == W'(MAX);
    always_comb cnt_d = clr ? '0 : (inc && !sat) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: one-grant-per-cycle CPU/DMA arbiter with registered memory port and read return
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW            = AW_DEF,
    parameter int DW            = DW_DEF,
    parameter int DMA_BURST_MAX = 4
) (
    input logic clk,
    input logic rst_n,
    mem_bus_arbiter_if.slave bus
);
    logic          cpu_gnt, dma_gnt, sat;
    gnt_e          win;
    logic          lock_q, lock_d, we_q, we_d, owner_q, owner_d, crv_q, crv_d, drv_q, drv_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    // lock only shuts out DMA; a saturated burst hands a contended cycle to the CPU
    always_comb begin
        cpu_gnt = bus.cpu_req && (!bus.dma_req || lock_q || sat);
        dma_gnt = bus.dma_req && !lock_q && !(bus.cpu_req && sat);
        win     = cpu_gnt ? GNT_CPU : dma_gnt ? GNT_DMA : GNT_NONE;
        addr_d  = win == GNT_CPU ? bus.cpu_addr  : win == GNT_DMA ? bus.dma_addr  : addr_q;
        wdata_d = win == GNT_CPU ? bus.cpu_wdata : win == GNT_DMA ? bus.dma_wdata : wdata_q;
        we_d    = win == GNT_CPU ? bus.cpu_we    : win == GNT_DMA ? bus.dma_we    : 1'b0;
        owner_d = win == GNT_CPU ? OWN_CPU       : win == GNT_DMA ? OWN_DMA       : owner_q;
        crv_d   = cpu_gnt && !bus.cpu_we;
        drv_d   = dma_gnt && !bus.dma_we;
        lock_d  = cpu_gnt ? bus.cpu_lock : lock_q && bus.cpu_lock;
    end
    arb_burst_ctr #(.MAX(DMA_BURST_MAX)) u_burst (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (dma_gnt),
        .clr  (cpu_gnt || !bus.dma_req),
        .sat  (sat)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            owner_q <= OWN_CPU;
            crv_q   <= 1'b0;
            drv_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            owner_q <= owner_d;
            crv_q   <= crv_d;
            drv_q   <= drv_d;
            lock_q  <= lock_d;
        end
    end
    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.cpu_rvalid = crv_q;
    assign bus.dma_rvalid = drv_q;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dma_rdata  = bus.mem_rdata;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.bus_owner  = owner_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic checked against a behavioural model
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;
    localparam int MAXB = 4;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;
    mem_bus_arbiter_if #(.AW(AW_DEF), .DW(DW_DEF)) bus ();
    mem_bus_arbiter #(.DMA_BURST_MAX(MAXB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    function automatic logic [7:0] pat(logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction
    assign bus.mem_rdata = pat(bus.mem_addr);
    int pass = 0, total = 0;
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        else pass++;
    endtask
    // model state: what the memory port must hold and how far the DMA streak has run
    int          m_streak = 0;
    bit          m_lock = 0, m_we = 0, m_owner = 0, m_crv = 0, m_drv = 0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    function automatic void grants(output bit c, output bit d);
        c = 0;
        d = 0;
        if (bus.cpu_req && bus.dma_req) begin
            if (m_lock || m_streak >= MAXB) c = 1;
            else d = 1;
        end else if (bus.cpu_req) c = 1;
        else if (bus.dma_req && !m_lock) d = 1;
    endfunction
    always @(posedge clk or negedge rst_n) begin
        bit c, d;
        if (!rst_n) begin
            m_streak <= 0; m_lock <= 0; m_we <= 0; m_owner <= 0;
            m_crv <= 0; m_drv <= 0; m_addr <= '0; m_wdata <= '0;
        end else begin
            grants(c, d);
            if (c) begin
                m_addr <= bus.cpu_addr; m_wdata <= bus.cpu_wdata; m_we <= bus.cpu_we; m_owner <= 0;
            end else if (d) begin
                m_addr <= bus.dma_addr; m_wdata <= bus.dma_wdata; m_we <= bus.dma_we; m_owner <= 1;
            end else m_we <= 0;
            m_crv  <= c && !bus.cpu_we;
            m_drv  <= d && !bus.dma_we;
            m_lock <= c ? bus.cpu_lock : (m_lock && bus.cpu_lock);
            m_streak <= (c || !bus.dma_req) ? 0 : d ? ((m_streak + 1 > MAXB) ? MAXB : m_streak + 1) : m_streak;
        end
    end
    bit cg = 0, dg = 0;
    always @(negedge clk) begin
        bit c, d;
        cg = bus.cpu_gnt;
        dg = bus.dma_gnt;
        if (rst_n) begin
            grants(c, d);
            chk("cpu_gnt", bus.cpu_gnt, c);
            chk("dma_gnt", bus.dma_gnt, d);
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_we", bus.mem_we, m_we);
            chk("mem_wdata", bus.mem_wdata, m_wdata);
            chk("bus_owner", bus.bus_owner, m_owner);
            chk("cpu_rvalid", bus.cpu_rvalid, m_crv);
            chk("dma_rvalid", bus.dma_rvalid, m_drv);
            chk("cpu_rdata", bus.cpu_rdata, pat(m_addr));
            chk("dma_rdata", bus.dma_rdata, pat(m_addr));
        end
    end
    task automatic idle();
        bus.cpu_req = 0; bus.cpu_addr = '0; bus.cpu_we = 0; bus.cpu_wdata = '0; bus.cpu_lock = 0;
        bus.dma_req = 0; bus.dma_addr = '0; bus.dma_we = 0; bus.dma_wdata = '0;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    logic [9:0] cv, dv;
    initial begin
        idle();
        #2;
        chk("rst_mem_addr", bus.mem_addr, 16'h0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_owner", bus.bus_owner, 0);
        chk("rst_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 2'b00);
        chk("rst_gnt", {bus.cpu_gnt, bus.dma_gnt}, 2'b00);
        step(); rst_n = 1;
        step(); bus.cpu_req = 1; bus.cpu_addr = 16'h1234;
        #1 chk("t1_gnt", bus.cpu_gnt, 1);
        step(); idle();
        #1 chk("t1_addr", bus.mem_addr, 16'h1234);
        chk("t1_we", bus.mem_we, 0);
        chk("t1_rvalid", bus.cpu_rvalid, 1);
        chk("t1_rdata", bus.cpu_rdata, 8'h1A);
        step(); bus.dma_req = 1; bus.dma_addr = 16'h0200; bus.dma_we = 1; bus.dma_wdata = 8'h5A;
        #1 chk("t2_gnt", bus.dma_gnt, 1);
        step(); idle();
        #1 chk("t2_we", bus.mem_we, 1);
        chk("t2_wdata", bus.mem_wdata, 8'h5A);
        chk("t2_owner", bus.bus_owner, 1);
        chk("t2_norvalid", bus.dma_rvalid, 0);
        step();
        #1 chk("t2_we_off", bus.mem_we, 0);
        chk("t2_owner_hold", bus.bus_owner, 1);
        step(); bus.cpu_req = 1; bus.cpu_we = 1; bus.dma_req = 1; bus.dma_we = 1;
        for (int i = 0; i < 10; i++) begin
            #1 cv[9-i] = bus.cpu_gnt; dv[9-i] = bus.dma_gnt;
            step();
        end
        idle();
        chk("t3_dma_pattern", dv, 10'b1111011110);
        chk("t3_cpu_pattern", cv, 10'b0000100001);
        step(); bus.cpu_req = 1; bus.cpu_lock = 1;
        #1 chk("t4_cpu_gnt", bus.cpu_gnt, 1);
        step(); bus.cpu_req = 0; bus.dma_req = 1; bus.dma_addr = 16'h0300;
        #1 chk("t4_blk0", bus.dma_gnt, 0);
        step();
        #1 chk("t4_blk1", bus.dma_gnt, 0);
        step(); bus.cpu_lock = 0;
        #1 chk("t4_blk_release", bus.dma_gnt, 0);
        step();
        #1 chk("t4_dma_gnt", bus.dma_gnt, 1);
        step(); idle(); bus.cpu_req = 1; bus.cpu_addr = 16'h0010;
        step(); idle(); bus.dma_req = 1; bus.dma_addr = 16'h0020;
        #1 chk("t5_crv", {bus.cpu_rvalid, bus.dma_rvalid}, 2'b10);
        chk("t5_crdata", bus.cpu_rdata, 8'h2C);
        step(); idle();
        #1 chk("t5_drv", {bus.cpu_rvalid, bus.dma_rvalid}, 2'b01);
        chk("t5_drdata", bus.dma_rdata, 8'h1C);
        step(); bus.cpu_req = 1; bus.cpu_addr = 16'h1234;
        step(); idle();
        chk("t6_pre_rvalid", bus.cpu_rvalid, 1);
        #1 rst_n = 0;
        #1 chk("t6_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 2'b00);
        chk("t6_we", bus.mem_we, 0);
        chk("t6_addr", bus.mem_addr, 16'h0);
        step(); rst_n = 1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!bus.cpu_req || cg) begin
                bus.cpu_req = $urandom_range(0, 3) != 0;
                bus.cpu_addr = 16'($urandom); bus.cpu_we = 1'($urandom); bus.cpu_wdata = 8'($urandom);
            end
            if (!bus.dma_req || dg) begin
                bus.dma_req = $urandom_range(0, 3) != 0;
                bus.dma_addr = 16'($urandom); bus.dma_we = 1'($urandom); bus.dma_wdata = 8'($urandom);
            end
            bus.cpu_lock = bus.cpu_lock ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
        end
        step(); idle();
        repeat (3) step();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
